// File: rtl/soc_system_busy_sched_pkg.sv
// Shared types and constants for the busy-line sequencer: FSM states,
// register map, field positions and the round-robin pick rule.
package soc_system_busy_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ACK,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_EVENT   = 2'd2;
  localparam logic [1:0] REG_JOBS    = 2'd3;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_GRANT_LSB  = 1;
  localparam int STAT_ACTIVE_BIT = 3;
  localparam int CTRL_EN_LSB     = 0;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int EV_DONE_BIT     = 0;
  localparam int EV_TIMEOUT_BIT  = 1;

  localparam logic [2:0] CTRL_RESET = 3'b011;

  // Returns the winning requester index. Requester 1 wins only when it is the
  // sole eligible one, or both are eligible and requester 0 owned last.
  function automatic logic rr_pick(input logic [1:0] elig, input logic last_owner);
    return elig[1] & (~elig[0] | ~last_owner);
  endfunction

endpackage

// File: rtl/soc_system_busy_sched_if.sv
// Avalon-MM register port plus the accelerator job handshake, bundled so the
// scheduler and its users share one port list.
interface soc_system_busy_sched_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busy_in;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        start;
  logic [1:0]  done;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata, busy_in, req,
    output readdata, grant, start, done, irq
  );

  modport master (
    output address, chipselect, write_n, writedata, busy_in, req,
    input  readdata, grant, start, done, irq
  );
endinterface

// File: rtl/soc_system_busy_sync.sv
// Multi-flop synchronizer bringing the accelerator busy line into clk domain.
module soc_system_busy_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy_in,
  output logic busy_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value from before the edge, giving a true shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], busy_in};
  end

  assign busy_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_busy_sched.sv
// Two-way arbiter and job sequencer for the shared accelerator, with an
// Avalon-MM status/control/event/jobs register file and a level interrupt.
module soc_system_busy_sched
  import soc_system_busy_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  soc_system_busy_sched_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic        busy_s;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        owner_q, owner_d;
  logic        set_done, set_timeout;
  logic [1:0]  elig;
  logic        pick;

  logic [1:0]  en_q;
  logic        irq_en_q;
  logic [1:0]  ev_q, ev_clr, ev_d;
  logic [15:0] jobs_q;
  logic        irq_q;
  logic [31:0] readdata_q, rd_mux;
  logic        wr_en;
  logic        unused_wdata;

  soc_system_busy_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .busy_in (bus.busy_in),
    .busy_s  (busy_s)
  );

  assign elig = bus.req & en_q;
  assign pick = rr_pick(elig, owner_q);

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig != 2'b00 && !busy_s) begin
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (busy_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          set_timeout = 1'b1;
          grant_d     = 2'b00;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        // Completion is booked on entry to DONE so the pulse, the sticky bit
        // and the count all become visible in the same cycle.
        if (!busy_s) begin
          set_done = 1'b1;
          grant_d  = 2'b00;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.start = (state_q == ST_START);
  assign bus.done  = (state_q != ST_DONE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:3];

  // Hardware set is OR'd after the W1C mask, so a simultaneous set wins.
  assign ev_clr = (wr_en && bus.address == REG_EVENT) ? bus.writedata[1:0] : 2'b00;
  always_comb begin
    ev_d                 = ev_q & ~ev_clr;
    ev_d[EV_DONE_BIT]    = ev_d[EV_DONE_BIT] | set_done;
    ev_d[EV_TIMEOUT_BIT] = ev_d[EV_TIMEOUT_BIT] | set_timeout;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      REG_STATUS: begin
        rd_mux[STAT_BUSY_BIT]                    = busy_s;
        rd_mux[STAT_GRANT_LSB +: 2]              = grant_q;
        rd_mux[STAT_ACTIVE_BIT]                  = (state_q != ST_IDLE);
      end
      REG_CONTROL: begin
        rd_mux[CTRL_EN_LSB +: 2]                 = en_q;
        rd_mux[CTRL_IRQ_EN_BIT]                  = irq_en_q;
      end
      REG_EVENT:   rd_mux[1:0]  = ev_q;
      REG_JOBS:    rd_mux[15:0] = jobs_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= CTRL_RESET[CTRL_EN_LSB +: 2];
      irq_en_q   <= CTRL_RESET[CTRL_IRQ_EN_BIT];
      ev_q       <= 2'b00;
      jobs_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (wr_en && bus.address == REG_CONTROL) begin
        en_q     <= bus.writedata[CTRL_EN_LSB +: 2];
        irq_en_q <= bus.writedata[CTRL_IRQ_EN_BIT];
      end
      ev_q <= ev_d;
      // A jobs write beats a same-cycle increment and leaves zero.
      if (wr_en && bus.address == REG_JOBS) jobs_q <= '0;
      else if (set_done)                    jobs_q <= jobs_q + 16'd1;
      irq_q      <= irq_en_q & (|ev_q);
      readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_soc_system_busy_sched.sv
// Self-checking bench for soc_system_busy_sched: register table, directed
// job/timeout/corner sequences, and randomized jobs against an arbitration model.
module tb_soc_system_busy_sched;
  import soc_system_busy_sched_pkg::*;

  localparam int ACK_TIMEOUT = 16;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  soc_system_busy_sched_if bus();

  soc_system_busy_sched #(.ACK_TIMEOUT(ACK_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic       model_last = 1'b1;
  logic [1:0] model_en = 2'b11;
  int         exp_jobs;
  logic [1:0] exp_ev;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[15];

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt++;
    if (|bus.done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Round-robin rule: a lone eligible requester wins; on a tie the one that
  // did not own the accelerator last wins.
  function automatic logic [1:0] model_grant(input logic [1:0] elig);
    if (elig == 2'b11) return model_last ? 2'b01 : 2'b10;
    return elig;
  endfunction

  task automatic wait_start(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Entered on the cycle start is high. delay<0 means busy never rises.
  // wr_mode 1/2 lands a jobs write / event W1C on the completion edge.
  task automatic finish_job(input logic [1:0] owner, input int delay, input int hold,
                            input int wr_mode);
    int   n;
    int   d0;
    logic held;
    tick();
    check("start_width", bus.start, 0);
    d0 = done_cnt;
    if (delay < 0) begin
      n = 1;
      while (bus.grant !== 2'b00 && n < 60) begin
        tick();
        n++;
      end
      check("timeout_lat", n, ACK_TIMEOUT + 1);
      check("timeout_no_done", done_cnt, d0);
    end else begin
      repeat (delay) tick();
      bus.busy_in = 1'b1;
      held = 1'b1;
      repeat (hold) begin
        tick();
        if (bus.grant !== owner) held = 1'b0;
      end
      bus.busy_in = 1'b0;
      n = 0;
      while (1) begin
        tick();
        n++;
        if (n == 2 && wr_mode == 1) begin
          bus.address = REG_JOBS; bus.writedata = 32'h0;
          bus.chipselect = 1'b1; bus.write_n = 1'b0;
        end
        if (n == 2 && wr_mode == 2) begin
          bus.address = REG_EVENT; bus.writedata = 32'h1;
          bus.chipselect = 1'b1; bus.write_n = 1'b0;
        end
        if (n == 3) begin
          bus.chipselect = 1'b0; bus.write_n = 1'b1;
        end
        if (|bus.done || n >= 60) break;
      end
      check("done_lat", n, SYNC_STAGES + 1);
      check("done_owner", bus.done, owner);
      check("grant_drop", bus.grant, 0);
      check("grant_held", held, 1);
    end
  endtask

  task automatic do_job(input logic [1:0] r, input bit drop, input int delay, input int hold,
                        input int wr_mode, output int w);
    logic [1:0] exp_o;
    exp_o = model_grant(r & model_en);
    bus.req = r;
    wait_start(w);
    check("start_seen", (w > 0), 1);
    if (w <= 0) begin
      bus.req = 2'b00;
      return;
    end
    check("grant_owner", bus.grant, exp_o);
    model_last = exp_o[1];
    if (drop) bus.req = 2'b00;
    finish_job(exp_o, delay, hold, wr_mode);
  endtask

  initial begin
    int          w;
    int          s0, d0;
    logic [31:0] d;
    logic [1:0]  r, en;
    logic        to;

    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.writedata = '0; bus.busy_in = 1'b0; bus.req = 2'b00;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_readdata", bus.readdata, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_start", bus.start, 0);
    check("rst_done", bus.done, 0);
    check("rst_irq", bus.irq, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Register table
    vecs[0]  = '{1'b0, REG_STATUS,  32'h0,        32'h0, "status_rst"};
    vecs[1]  = '{1'b0, REG_CONTROL, 32'h0,        32'h3, "ctrl_rst"};
    vecs[2]  = '{1'b0, REG_EVENT,   32'h0,        32'h0, "event_rst"};
    vecs[3]  = '{1'b0, REG_JOBS,    32'h0,        32'h0, "jobs_rst"};
    vecs[4]  = '{1'b1, REG_CONTROL, 32'hFFFFFFF8, 32'h0, "w"};
    vecs[5]  = '{1'b0, REG_CONTROL, 32'h0,        32'h0, "ctrl_zero"};
    vecs[6]  = '{1'b1, REG_CONTROL, 32'h5,        32'h0, "w"};
    vecs[7]  = '{1'b0, REG_CONTROL, 32'h0,        32'h5, "ctrl_rw"};
    vecs[8]  = '{1'b1, REG_EVENT,   32'h3,        32'h0, "w"};
    vecs[9]  = '{1'b0, REG_EVENT,   32'h0,        32'h0, "event_w1c_idle"};
    vecs[10] = '{1'b1, REG_JOBS,    32'h1234,     32'h0, "w"};
    vecs[11] = '{1'b0, REG_JOBS,    32'h0,        32'h0, "jobs_wr_clear"};
    vecs[12] = '{1'b1, REG_CONTROL, 32'h3,        32'h0, "w"};
    vecs[13] = '{1'b0, REG_CONTROL, 32'h0,        32'h3, "ctrl_restore"};
    vecs[14] = '{1'b0, REG_STATUS,  32'h0,        32'h0, "status_idle"};
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    check("irq_no_event", bus.irq, 0);
    model_en = 2'b11;

    // Round robin with both requesters held
    do_job(2'b11, 1'b0, 2, 4, 0, w);
    do_job(2'b11, 1'b0, 1, 5, 0, w);
    check("rr_gap1", w, 2);
    do_job(2'b11, 1'b1, 3, 3, 0, w);
    check("rr_gap2", w, 2);

    // Single job
    wr(REG_JOBS, 0);
    wr(REG_EVENT, 3);
    tick();
    s0 = start_cnt; d0 = done_cnt;
    do_job(2'b01, 1'b1, 3, 10, 0, w);
    tick();
    check("single_starts", start_cnt - s0, 1);
    check("single_dones", done_cnt - d0, 1);
    rd_check(REG_JOBS, 1, "single_jobs");
    rd_check(REG_EVENT, 1, "single_event");

    // Timeout with interrupt
    wr(REG_EVENT, 3);
    wr(REG_CONTROL, 7);
    do_job(2'b01, 1'b1, -1, 0, 0, w);
    rd(REG_EVENT, d);
    check("to_event", d, 2);
    check("to_irq_set", bus.irq, 1);
    rd_check(REG_JOBS, 1, "to_jobs_kept");
    wr(REG_EVENT, 2);
    tick();
    check("to_irq_clear", bus.irq, 0);
    wr(REG_CONTROL, 3);

    // Foreign busy holds off arbitration
    bus.busy_in = 1'b1;
    repeat (4) tick();
    bus.req = 2'b01;
    s0 = start_cnt;
    repeat (10) tick();
    check("foreign_no_start", start_cnt, s0);
    bus.busy_in = 1'b0;
    wait_start(w);
    check("foreign_lat", w, SYNC_STAGES + 1);
    check("foreign_grant", bus.grant, model_grant(2'b01 & model_en));
    model_last = 1'b0;
    bus.req = 2'b00;
    finish_job(2'b01, 2, 4, 0);

    // Jobs wrap, write-vs-increment, set-vs-W1C
    force dut.jobs_q = 16'hFFFF;
    tick();
    release dut.jobs_q;
    do_job(2'b01, 1'b1, 2, 3, 0, w);
    rd_check(REG_JOBS, 0, "jobs_wrap");
    do_job(2'b01, 1'b1, 1, 3, 0, w);
    rd_check(REG_JOBS, 1, "jobs_after_wrap");
    do_job(2'b01, 1'b1, 1, 3, 1, w);
    rd_check(REG_JOBS, 0, "jobs_wr_vs_inc");
    wr(REG_EVENT, 3);
    do_job(2'b01, 1'b1, 1, 3, 2, w);
    rd_check(REG_EVENT, 1, "ev_set_vs_w1c");

    // Randomized jobs against the model
    wr(REG_EVENT, 3);
    wr(REG_JOBS, 0);
    exp_jobs = 0;
    exp_ev = 2'b00;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        en = 2'($urandom_range(0, 3));
        wr(REG_CONTROL, {30'b0, en});
        model_en = en;
      end
      r = 2'($urandom_range(0, 3));
      if ((r & model_en) == 2'b00) begin
        bus.req = r;
        s0 = start_cnt;
        repeat (6) tick();
        check("rand_no_start", start_cnt, s0);
        bus.req = 2'b00;
      end else begin
        to = ($urandom_range(0, 3) == 0);
        do_job(r, 1'b1, to ? -1 : int'($urandom_range(0, 8)), int'($urandom_range(1, 10)), 0, w);
        if (to) exp_ev[1] = 1'b1;
        else begin
          exp_jobs++;
          exp_ev[0] = 1'b1;
        end
      end
      tick();
    end
    rd_check(REG_JOBS, exp_jobs & 32'hFFFF, "rand_jobs");
    rd_check(REG_EVENT, {30'b0, exp_ev}, "rand_event");
    wr(REG_CONTROL, 3);
    model_en = 2'b11;

    // Reset in the middle of RUN
    wr(REG_EVENT, 3);
    wr(REG_CONTROL, 7);
    bus.req = 2'b01;
    wait_start(w);
    check("rst_job_start", (w > 0), 1);
    bus.req = 2'b00;
    repeat (2) tick();
    bus.busy_in = 1'b1;
    repeat (6) tick();
    rd(REG_STATUS, d);
    check("status_run", d, 32'hB);
    reset_n = 1'b0;
    #1;
    check("midrst_grant", bus.grant, 0);
    check("midrst_start", bus.start, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_irq", bus.irq, 0);
    check("midrst_readdata", bus.readdata, 0);
    d0 = done_cnt;
    repeat (3) tick();
    bus.busy_in = 1'b0;
    reset_n = 1'b1;
    model_last = 1'b1;
    repeat (6) tick();
    check("midrst_no_done", done_cnt, d0);
    rd_check(REG_CONTROL, 3, "midrst_ctrl");
    rd_check(REG_EVENT, 0, "midrst_event");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soc_system_busy_sched.md
# soc_system_busy_sched

Sequencer and two-way arbiter for the shared accelerator whose single `busy` status line is exposed to the HPS as a PIO input. The block grants the accelerator to one of two fabric requesters, pulses its start, tracks `busy` through rise and fall, and reports completion back to the owner. An Avalon-MM slave gives software status, enables, sticky events, a job counter and an interrupt.

## Interface
- `ACK_TIMEOUT`, 16: cycles allowed between `start` and the synchronized `busy` rise before the job is abandoned (2..255).
- `SYNC_STAGES`, 2: synchronizer depth on `busy_in` (≥2).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon register select.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  active-low write strobe, valid with `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `busy_in`  in  1  accelerator busy, asynchronous to `clk`.
- `req`  in  2  per-requester job request, level.
- `grant`  out  2  one-hot owner, held for the whole job.
- `start`  out  1  one-cycle accelerator start pulse.
- `done`  out  2  one-cycle completion pulse to the owner.
- `irq`  out  1  level interrupt.

## Operation
- `busy_s` is `busy_in` after `SYNC_STAGES` flops. The FSM uses only `busy_s`.
- Register map:
  - 0, status, RO: bit0 `busy_s`; bits2:1 `grant`; bit3 FSM not IDLE.
  - 1, control, RW: bits1:0 requester enable (reset 2'b11); bit2 `irq_en` (reset 0).
  - 2, event, RW1C: bit0 done sticky; bit1 timeout sticky.
  - 3, jobs, RO: 16-bit completed-job count in bits15:0. Any write clears it.
  - Unused bits read 0.
- `irq = irq_en & (event[0] | event[1])`.
- FSM states:
  - IDLE:
    - Eligible set is `req & enable`.
    - If the eligible set is nonzero and `busy_s==0`, pick the owner by round-robin (the last owner has lower priority; after reset requester 0 wins ties). Load `grant` and go to START.
    - While `busy_s==1` (foreign use), wait.
  - START: `start=1` for this one cycle; clear the timeout counter; go to ACK.
  - ACK:
    - If `busy_s`, go to RUN.
    - Else if counter == `ACK_TIMEOUT-1`: set the timeout event, clear `grant`, go to IDLE. No `done` pulse, no count.
    - Else increment the counter.
  - RUN: when `busy_s==0`, go to DONE.
  - DONE: `done[owner]=1` for one cycle; set the done event; increment jobs (wraps 0xFFFF→0); clear `grant`; go to IDLE.
- `req` is sampled only in IDLE. Deasserting it mid-job does not abort the job.
- Clearing an enable bit mid-job affects only the next arbitration.
- Simultaneous events:
  - Hardware event set and W1C of the same bit in the same cycle: the set wins.
  - Jobs write and increment in the same cycle: the result is 0.

## Timing
- Reset values: `readdata`, `grant`, `start`, `done`, `irq`, event bits, jobs, counter and synchronizer all 0. Enable = 2'b11, FSM = IDLE, round-robin pointer favours requester 0.
- Reset asserted mid-job returns everything to reset values immediately. No `done` pulse is emitted.
- `readdata` is updated every clock from `address` (one-cycle read latency), independent of `chipselect`.
- Writes take effect on the clock edge where `chipselect & ~write_n`.
- If the request is seen in IDLE at edge t, then `grant` and `start` are high from t+1 and `start` falls at t+2.
- A `busy_in` rise appears on `busy_s` `SYNC_STAGES` edges later. The fall is likewise delayed.
- `done` is high the cycle after the edge where RUN sees `busy_s==0`, and `grant` drops on the same edge.
- Minimum spacing between back-to-back jobs: one IDLE cycle.
- Timeout fires exactly `ACK_TIMEOUT` cycles after START.
- `irq` is registered and follows event/`irq_en` changes by one cycle.

## Structure
- Package `soc_system_busy_sched_pkg` holds:
  - the FSM state enum (IDLE, START, ACK, RUN, DONE);
  - register address constants (`REG_STATUS`..`REG_JOBS`);
  - field bit positions;
  - reset value of control.
- Sub-module `soc_system_busy_sync`: parameterised `SYNC_STAGES` synchronizer, output `busy_s`.

## Test plan
- Pulse `req=2'b01`, `busy_in` high 3 cycles after `start` and held 10 cycles → one `start`, `grant=01` throughout, `done=01` once, jobs=1, event=1.
- `req=2'b11` held, three jobs completed → grants 01, 10, 01, with `start` pulses spaced by whole jobs.
- `busy_in` never rises → timeout event set exactly 16 cycles after `start`, no `done`, jobs unchanged. With `irq_en=1`, `irq=1`; write 2 to register 2 → `irq=0`.
- `busy_in` held high before any request → no `start` until it falls plus sync delay, then normal job.
- Jobs preset to 0xFFFF by running jobs (or forced in the bench) plus one job → reads 0. A jobs write in the same cycle as an increment → reads 0.
- `reset_n` pulsed low during RUN → all outputs 0 within the reset, no `done`. After release, control reads 3.
